// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: word width, checker FSM state encodings and the
// single-step LFSR function used by the checker and the processor core.
package lfsr_pkg;

  localparam int WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // One LFSR step. Words are held in descending vectors, so the spec-level
  // bit Q[i] lives at q[WIDTH-1-i]; the feedback bit Q[WIDTH-1] is q[0].
  // Q[0] takes the feedback bit, every other bit shifts down one position
  // and is XORed with the feedback bit where its tap is set.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] q,
                                                 input logic [WIDTH-2:0] tap);
    logic [WIDTH-1:0] n;
    n[WIDTH-1] = q[0];
    for (int j = 0; j < WIDTH-1; j++) begin
      n[j] = q[j+1] ^ (q[0] & tap[j]);
    end
    return n;
  endfunction

endpackage

// File: rtl/hd_popcount.sv
// Hamming distance between two words: XOR followed by a population count.
module hd_popcount #(
  parameter int WIDTH = 8,
  localparam int HW = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [HW-1:0]    hd
);

  logic [WIDTH-1:0] diff;

  assign diff = a ^ b;

  // Count the differing bit positions.
  always_comb begin
    hd = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hd = hd + HW'(diff[i]);
    end
  end

endmodule

// File: rtl/lfsr_pattern_checker.sv
// Reads a block of stored patterns from memory and compares each word
// against an LFSR-generated expected sequence, accumulating mismatch
// statistics (error count, first failing address, total Hamming distance).
module lfsr_pattern_checker #(
  parameter int WIDTH = lfsr_pkg::WIDTH,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-2:0] tap,
  input  logic [0:WIDTH-1] seed,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW-1:0]    count,
  output logic             mem_rd_en,
  output logic [AW-1:0]    mem_addr,
  input  logic [0:WIDTH-1] mem_rdata,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [AW:0]      err_count,
  output logic [AW-1:0]    first_err_addr,
  output logic [11:0]      hd_total
);

  import lfsr_pkg::*;

  localparam int HW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-2:0] tap_q;
  logic [WIDTH-1:0] exp_q;
  logic [WIDTH-1:0] rdata_vec;
  logic [AW-1:0]    addr_q;
  logic [AW-1:0]    cmp_addr;
  logic [AW:0]      remaining;
  logic             cmp_valid;
  logic             accept;
  logic [HW-1:0]    hd;
  logic             hd_nz;

  // Positional copy: mem_rdata[0] lands on the MSB, the same mapping the
  // seed gets when it is loaded into exp_q.
  assign rdata_vec = mem_rdata;
  assign accept    = (state == ST_IDLE) && start;
  assign hd_nz     = (hd != '0);

  assign mem_rd_en = (state == ST_RUN);
  assign mem_addr  = addr_q;
  assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
  assign done      = (state == ST_DONE);

  hd_popcount #(.WIDTH(WIDTH)) u_hd_popcount (
    .a  (rdata_vec),
    .b  (exp_q),
    .hd (hd)
  );

  // Run control: latch the run setup, step the read address and word count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tap_q     <= '0;
      addr_q    <= '0;
      remaining <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_RUN;
            tap_q     <= tap;
            addr_q    <= base_addr;
            remaining <= (count == '0) ? {1'b1, {AW{1'b0}}} : {1'b0, count};
          end
        end
        ST_RUN: begin
          addr_q    <= addr_q + 1'b1;
          remaining <= remaining - 1'b1;
          if (remaining == (AW+1)'(1)) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Compare pipeline: read data returns one cycle after the strobe, so the
  // address and valid flag are delayed to line up with it; the expected
  // word advances after each comparison.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_valid <= 1'b0;
      cmp_addr  <= '0;
      exp_q     <= '0;
    end else begin
      cmp_valid <= (state == ST_RUN);
      cmp_addr  <= addr_q;
      if (accept) begin
        exp_q <= seed;
      end else if (cmp_valid) begin
        exp_q <= lfsr_step(exp_q, tap_q);
      end
    end
  end

  // Result accumulation: cleared on an accepted start, updated per compared
  // word, with the verdict taken as the final word is compared in DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count      <= '0;
      first_err_addr <= '0;
      hd_total       <= '0;
      pass           <= 1'b0;
    end else if (accept) begin
      err_count      <= '0;
      first_err_addr <= '0;
      hd_total       <= '0;
      pass           <= 1'b0;
    end else if (cmp_valid) begin
      hd_total <= hd_total + 12'(hd);
      if (hd_nz) begin
        err_count <= err_count + 1'b1;
        if (err_count == '0) begin
          first_err_addr <= cmp_addr;
        end
      end
      if (state == ST_DRAIN) begin
        pass <= (err_count == '0) && !hd_nz;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_pattern_checker.sv
// Directed testbench for lfsr_pattern_checker with a one-cycle-latency
// pattern memory model and hand-computed expected results.
module tb_lfsr_pattern_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  tap = '0;
  logic [0:7]  seed = '0;
  logic [7:0]  base_addr = '0;
  logic [7:0]  count = '0;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [0:7]  mem_rdata = '0;
  logic        busy;
  logic        done;
  logic        pass;
  logic [8:0]  err_count;
  logic [7:0]  first_err_addr;
  logic [11:0] hd_total;

  logic [7:0]  mem [256];

  int checks = 0;
  int errors = 0;

  int          done_cycle;
  int          done_pulses;
  int          busy_cycles;
  int          read_count;
  logic        busy_at_done;
  logic [7:0]  addr_log [4];

  lfsr_pattern_checker #(.WIDTH(8), .AW(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .tap            (tap),
    .seed           (seed),
    .base_addr      (base_addr),
    .count          (count),
    .mem_rd_en      (mem_rd_en),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .hd_total       (hd_total)
  );

  always #5 clk = ~clk;

  // Pattern memory: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clearMem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  // Pulse start (sampled at edge 0), then observe cycles 1..max_cycles at
  // the falling edge. Optionally re-pulse start or pulse reset in a cycle.
  task automatic applyStimulus(input logic [6:0] t, input logic [7:0] s,
                               input logic [7:0] b, input logic [7:0] n,
                               input int restart_at, input int reset_at,
                               input int max_cycles);
    @(negedge clk);
    tap = t; seed = s; base_addr = b; count = n; start = 1'b1;
    done_cycle = -1; done_pulses = 0; busy_cycles = 0; read_count = 0;
    busy_at_done = 1'bx;
    for (int i = 0; i < 4; i++) addr_log[i] = 8'hxx;
    for (int c = 1; c <= max_cycles; c++) begin
      @(negedge clk);
      if (done) begin
        done_pulses++;
        if (done_cycle < 0) begin
          done_cycle = c;
          busy_at_done = busy;
        end
      end
      if (busy) busy_cycles++;
      if (mem_rd_en) begin
        if (read_count < 4) addr_log[read_count] = mem_addr;
        read_count++;
      end
      start = (c == restart_at);
      if (c == reset_at) begin
        rst_n = 1'b0;
        #1;
        checkOutput("rst_rd_en", mem_rd_en, 0);
        checkOutput("rst_addr", mem_addr, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_pass", pass, 0);
        checkOutput("rst_err", err_count, 0);
        checkOutput("rst_first", first_err_addr, 0);
        checkOutput("rst_hd", hd_total, 0);
        #1 rst_n = 1'b1;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    clearMem();

    // Reset state
    #3;
    checkOutput("reset_rd_en", mem_rd_en, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_pass", pass, 0);
    checkOutput("reset_err", err_count, 0);
    checkOutput("reset_hd", hd_total, 0);
    checkOutput("reset_first", first_err_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean rotation run: tap=0, seed=01, 4 words at 10h
    mem[8'h10] = 8'h01; mem[8'h11] = 8'h80; mem[8'h12] = 8'h40; mem[8'h13] = 8'h20;
    applyStimulus(7'h00, 8'h01, 8'h10, 8'd4, -1, -1, 12);
    checkOutput("t1_done_cycle", done_cycle, 6);
    checkOutput("t1_busy_at_done", busy_at_done, 0);
    checkOutput("t1_busy_cycles", busy_cycles, 5);
    checkOutput("t1_reads", read_count, 4);
    checkOutput("t1_done_pulses", done_pulses, 1);
    checkOutput("t1_addr0", addr_log[0], 8'h10);
    checkOutput("t1_addr3", addr_log[3], 8'h13);
    checkOutput("t1_pass", pass, 1);
    checkOutput("t1_err", err_count, 0);
    checkOutput("t1_hd", hd_total, 0);
    checkOutput("t1_first", first_err_addr, 0);

    // Same run with one corrupted word: 43h vs expected 40h, distance 2
    mem[8'h12] = 8'h43;
    applyStimulus(7'h00, 8'h01, 8'h10, 8'd4, -1, -1, 12);
    checkOutput("t2_pass", pass, 0);
    checkOutput("t2_err", err_count, 1);
    checkOutput("t2_first", first_err_addr, 8'h12);
    checkOutput("t2_hd", hd_total, 2);

    // Start re-pulsed in cycle 2 of a run is ignored
    applyStimulus(7'h00, 8'h01, 8'h10, 8'd4, 2, -1, 12);
    checkOutput("t6_done_cycle", done_cycle, 6);
    checkOutput("t6_done_pulses", done_pulses, 1);
    checkOutput("t6_reads", read_count, 4);
    checkOutput("t6_err", err_count, 1);
    checkOutput("t6_hd", hd_total, 2);
    checkOutput("t6_first", first_err_addr, 8'h12);

    // Address wrap at FFh
    clearMem();
    mem[8'hFE] = 8'h01; mem[8'hFF] = 8'h80; mem[8'h00] = 8'h40; mem[8'h01] = 8'h20;
    applyStimulus(7'h00, 8'h01, 8'hFE, 8'd4, -1, -1, 12);
    checkOutput("t3_addr0", addr_log[0], 8'hFE);
    checkOutput("t3_addr1", addr_log[1], 8'hFF);
    checkOutput("t3_addr2", addr_log[2], 8'h00);
    checkOutput("t3_addr3", addr_log[3], 8'h01);
    checkOutput("t3_pass", pass, 1);

    // Tapped LFSR: tap=41h, seed=02h -> 02, 01, C1, A1
    clearMem();
    mem[8'h20] = 8'h02; mem[8'h21] = 8'h01; mem[8'h22] = 8'hC1; mem[8'h23] = 8'hA1;
    applyStimulus(7'h41, 8'h02, 8'h20, 8'd4, -1, -1, 12);
    checkOutput("t4_pass", pass, 1);
    checkOutput("t4_err", err_count, 0);
    checkOutput("t4_hd", hd_total, 0);

    // count=0 means 256 words; zero seed gives an all-zero expected stream
    clearMem();
    mem[8'h80] = 8'hFF; mem[8'h00] = 8'h01;
    applyStimulus(7'h7F, 8'h00, 8'h10, 8'd0, -1, -1, 264);
    checkOutput("t5_reads", read_count, 256);
    checkOutput("t5_busy_cycles", busy_cycles, 257);
    checkOutput("t5_done_cycle", done_cycle, 258);
    checkOutput("t5_err", err_count, 2);
    checkOutput("t5_hd", hd_total, 9);
    checkOutput("t5_first", first_err_addr, 8'h80);
    checkOutput("t5_pass", pass, 0);

    // Reset in cycle 3 aborts the run; start held across the reset release
    // is taken on the next edge and that run completes normally (done in 9)
    clearMem();
    mem[8'h10] = 8'h01; mem[8'h11] = 8'h80; mem[8'h12] = 8'h40; mem[8'h13] = 8'h20;
    applyStimulus(7'h00, 8'h01, 8'h10, 8'd4, 3, 3, 14);
    checkOutput("t7_done_pulses", done_pulses, 1);
    checkOutput("t7_done_cycle", done_cycle, 9);
    checkOutput("t7_reads", read_count, 7);
    checkOutput("t7_pass", pass, 1);
    checkOutput("t7_err", err_count, 0);
    checkOutput("t7_hd", hd_total, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lfsr_pattern_checker.md
LFSR_PATTERN_CHECKER -- requirements
Module: lfsr_pattern_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 8, LFSR/data word width.
REQ-002 SHALL have parameter AW, default 8, pattern-memory address width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, one-cycle request to begin a check run.
REQ-006 SHALL have port tap, input, [6:0], tap configuration, same bit meaning as config_tap.
REQ-007 SHALL have port seed, input, [0:7], expected first pattern.
REQ-008 SHALL have port base_addr, input, [7:0], memory address of the first stored pattern.
REQ-009 SHALL have port count, input, [7:0], number of words to check; 0 means 256.
REQ-010 SHALL have port mem_rd_en, output, 1, pattern-memory read strobe.
REQ-011 SHALL have port mem_addr, output, [7:0], pattern-memory read address.
REQ-012 SHALL have port mem_rdata, input, [0:7], read data, valid exactly one cycle after mem_rd_en.
REQ-013 SHALL have port busy, output, 1, high while a run is in progress.
REQ-014 SHALL have port done, output, 1, one-cycle pulse at run completion.
REQ-015 SHALL have port pass, output, 1, high when the last completed run had zero mismatching words.
REQ-016 SHALL have port err_count, output, [8:0], number of mismatching words.
REQ-017 SHALL have port first_err_addr, output, [7:0], address of the first mismatching word, 0 if none.
REQ-018 SHALL have port hd_total, output, [11:0], sum of per-word Hamming distances.

Function
REQ-019 SHALL compute the expected sequence as E0=seed, Ek+1=step(Ek), where step is: Q[0]<=Q[7]; for i=1..7, Q[i]<=Q[i-1]^(Q[7]&tap[7-i]).
REQ-020 SHALL implement FSM states IDLE, RUN, DRAIN, DONE; reset state is IDLE.
REQ-021 SHALL, in IDLE, move to RUN when start=1 is sampled and latch tap, seed, base_addr and count, with count=0 latched as 256.
REQ-022 SHALL, on the start edge, clear err_count, hd_total and first_err_addr, and drive pass low.
REQ-023 SHALL, in RUN, assert mem_rd_en every cycle with mem_addr=base_addr+k for k=0..N-1, addition mod 256 so the address wraps from 8'hFF to 8'h00.
REQ-024 SHALL, one cycle after each read, compute hd=popcount(mem_rdata^Ek), add it to hd_total, increment err_count when hd!=0, and capture first_err_addr on the first nonzero hd only.
REQ-025 SHALL enter DRAIN after issuing the Nth read, and DRAIN SHALL last one cycle and compare the final word.
REQ-026 SHALL, for the timing of a run (start sampled at edge 0, N words):
  - reads are issued in cycles 1..N;
  - busy is high in cycles 1..N+1;
  - the DONE state lasts one cycle, N+2, in which done=1 and busy=0;
  - the FSM returns to IDLE after DONE.
REQ-027 SHALL set pass=(err_count==0) in the DONE cycle and hold pass, err_count, hd_total and first_err_addr until the next accepted start.
REQ-028 SHALL ignore start while busy or in DONE.
REQ-029 SHALL hold mem_rd_en low outside RUN; mem_addr is don't-care when mem_rd_en is low.
REQ-030 SHALL treat tap=0 as a pure rotation and seed=0 as an all-zero expected sequence; neither is an error.
REQ-031 SHALL require no saturation logic, since the widths hold the maximum values (err_count 256, hd_total 2048).

Reset
REQ-032 SHALL, while rst_n=0, immediately force state IDLE and drive all outputs to 0: mem_rd_en, mem_addr, busy, done, pass, err_count, first_err_addr, hd_total.
REQ-033 SHALL abort any run in progress on reset, with no done pulse, and SHALL accept start on the first clock edge after rst_n deasserts.

Structure
REQ-034 SHALL place the FSM state enum, WIDTH, and the lfsr_step function in shared package lfsr_pkg, which the processor core also uses for its run instruction.
REQ-035 SHALL instantiate one sub-module, hd_popcount (WIDTH-bit XOR plus popcount, combinational), for the per-word Hamming distance.

Verification
REQ-036 SHALL cover: tap=0, seed=8'h01, base=8'h10, count=4, memory 01,80,40,20 -> done in cycle 6, pass=1, err_count=0, hd_total=0.
REQ-037 SHALL cover: same as REQ-036 with M[8'h12]=8'h43 -> pass=0, err_count=1, first_err_addr=8'h12, hd_total=2.
REQ-038 SHALL cover: base=8'hFE, count=4 -> mem_addr sequence FE,FF,00,01 on consecutive cycles.
REQ-039 SHALL cover: count=0 -> 256 reads, busy for 257 cycles, done in cycle 258.
REQ-040 SHALL cover: rst_n low in cycle 3 of a run -> all outputs 0 that cycle, no done pulse; a new start then completes normally.
REQ-041 SHALL cover: start pulsed in cycle 2 of a run -> ignored, exactly one done pulse, and results match a single run.
